// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_arbiter                                                 |
// | Description : Single-port data-memory arbiter between the pipeline MEM     |
// |               stage and a loader/debug requester. Fixed CPU priority with  |
// |               a starvation bound for the loader; optional loader lock for  |
// |               burst transfers, enabled by defining DMEM_ARB_LOCK_EN.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    // MEM stage
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    // loader / debug requester
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_ack,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              ld_lock,
`endif
    output logic              locked,
    // data memory
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] c_starve_max = 8'(STARVE_MAX);

    logic              r_ld_ack;
    logic [DATA_W-1:0] r_ld_rdata;
    logic [7:0]        r_starve_cnt;
    logic              w_locked;
    logic              w_starved;
    logic              w_ld_gnt;
    logic              w_cpu_gnt;

    // Grants: the loader wins when idle CPU, starvation limit reached, or locked.
    // The ack cycle always blocks the loader so a held request is not re-served.
    assign w_starved = (r_starve_cnt == c_starve_max);
    assign w_ld_gnt  = reset & ld_req & ~r_ld_ack & (w_locked | ~cpu_req | w_starved);
    assign w_cpu_gnt = reset & cpu_req & ~w_ld_gnt & ~w_locked;
    assign cpu_stall = reset & cpu_req & ~w_cpu_gnt;

    // Read data goes straight back to MEM/WB; only meaningful when not stalled.
    assign cpu_rdata = mem_rdata;
    assign ld_rdata  = r_ld_rdata;
    assign ld_ack    = r_ld_ack;
    assign locked    = w_locked;

    // Memory port mux: granted requester drives the port, otherwise all zero.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (w_ld_gnt) begin
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            mem_we    = ld_we;
            mem_re    = ~ld_we;
        end else if (w_cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
            mem_re    = ~cpu_we;
        end
    end

    // Loader handshake: ack one cycle after grant, capture read data on reads.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ld_ack   <= 1'b0;
            r_ld_rdata <= '0;
        end else begin
            r_ld_ack <= w_ld_gnt;
            if (w_ld_gnt && !ld_we) begin
                r_ld_rdata <= mem_rdata;
            end
        end
    end

    // Starvation counter: counts consecutive denied loader cycles, saturating.
    // Ack cycles neither count nor clear so a back-to-back requester keeps credit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (w_ld_gnt || !ld_req) begin
            r_starve_cnt <= '0;
        end else if (!r_ld_ack && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    logic r_locked;

    // Lock ownership: taken on a granted cycle with ld_lock, released once the
    // loader has dropped both lock and request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_locked <= 1'b0;
        end else if (w_ld_gnt && ld_lock) begin
            r_locked <= 1'b1;
        end else if (!ld_lock && !ld_req) begin
            r_locked <= 1'b0;
        end
    end

    assign w_locked = r_locked;
`else
    assign w_locked = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter between the pipeline's MEM stage and a loader/debug requester (boot loader, host DMA). Sits between the EX/MEM register outputs and the data memory, muxes address, write data and strobes to the granted requester, and stalls the pipeline when the loader wins. Uses fixed CPU priority with a starvation bound for the loader and an optional loader lock for burst transfers.

## Interface
- ADDR_W, 11, word-address width (byte address bits [12:2])
- DATA_W, 32, data width
- STARVE_MAX, 8, consecutive denied loader cycles before the loader is forced a grant (1..255)

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  MEM stage access this cycle (MemRead or MemWrite)
- cpu_we  in  1  CPU write strobe
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data (after forwarding)
- cpu_rdata  out  DATA_W  read data to MEM/WB
- cpu_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- ld_req  in  1  loader request, held with stable fields until ld_ack
- ld_we  in  1  loader write strobe
- ld_addr  in  ADDR_W  loader word address
- ld_wdata  in  DATA_W  loader write data
- ld_rdata  out  DATA_W  registered loader read data
- ld_ack  out  1  one-cycle pulse: loader access completed
- ld_lock  in  1  request exclusive ownership (only with DMEM_ARB_LOCK_EN)
- locked  out  1  loader holds exclusive ownership
- mem_addr  out  ADDR_W  to data memory
- mem_wdata  out  DATA_W  to data memory
- mem_we  out  1  to data memory
- mem_re  out  1  to data memory
- mem_rdata  in  DATA_W  combinational read data from memory

## Operation
- Per-cycle grant (combinational from inputs and registered state):
  - ld_gnt = reset & ld_req & !ld_ack & (locked | !cpu_req | starve_cnt == STARVE_MAX)
  - cpu_gnt = reset & cpu_req & !ld_gnt & !locked
  - cpu_stall = reset & cpu_req & !cpu_gnt
- Memory mux: ld_gnt drives ld_* fields; cpu_gnt drives cpu_* fields; neither: mem_we = mem_re = 0, mem_addr/mem_wdata = 0. mem_re = gnt & !we.
- cpu_rdata = mem_rdata unconditionally; only meaningful when !cpu_stall.
- starve_cnt (8-bit, saturating at STARVE_MAX): cleared on ld_gnt, on !ld_req, or on reset; incremented when ld_req & !ld_gnt & !ld_ack.
- Loader handshake: on a granted cycle, ld_rdata <= mem_rdata (reads only; writes leave it unchanged) and ld_ack <= 1 next cycle. Loader is never granted while ld_ack = 1, so loader throughput is at most one access per 2 cycles; ld_req high during the ack cycle is a new request.
- Simultaneous cpu_req & ld_req with starve_cnt < STARVE_MAX: CPU wins.
- Reset low: all registers cleared, no grants, cpu_stall = 0; reset asserted mid-access drops any pending ld_ack.

## Timing
- Reset values: cpu_stall 0, ld_ack 0, ld_rdata 0, locked 0, mem_we 0, mem_re 0, mem_addr 0, mem_wdata 0, starve_cnt 0.
- CPU access: zero added latency when granted; write commits on the same clock edge as the memory write.
- Loader access: ack one cycle after grant; worst-case grant latency under continuous cpu_req = STARVE_MAX + 1 cycles from ld_req rise.
- Stall is combinational same-cycle; the CPU re-presents the identical access next cycle.

## Configuration
- DMEM_ARB_LOCK_EN defined: ld_lock exists; locked <= 1 on any ld_gnt cycle with ld_lock = 1; locked <= 0 on the first cycle with ld_lock = 0 and ld_req = 0. While locked, CPU is never granted (cpu_stall = cpu_req) and loader grants ignore cpu_req.
- Not defined: ld_lock port absent, locked tied to 0, arbitration as above without lock terms.

## Test plan
- cpu_req only, write 0xDEADBEEF to addr 0x010 then read -> cpu_stall 0 both cycles, cpu_rdata 0xDEADBEEF.
- ld_req read addr 0x020 (holds 0x12345678), cpu_req low -> mem_re in cycle 0, ld_ack and ld_rdata = 0x12345678 in cycle 1, no grant in cycle 1.
- cpu_req held high, ld_req raised, STARVE_MAX = 8 -> CPU granted 8 cycles, loader granted cycle 9 with cpu_stall 1, ld_ack cycle 10, CPU regranted cycle 10.
- cpu_req & ld_req rise together, starve_cnt 0 -> CPU granted, starve_cnt = 1 next cycle.
- Loader granted, reset driven low on the ack cycle edge -> ld_ack 0, ld_rdata 0, starve_cnt 0 after edge.
- (LOCK_EN) ld_lock = 1 with 4 writes, cpu_req high throughout -> locked 1 from first grant, cpu_stall 1 until ld_lock and ld_req both low, then CPU granted next cycle.
